lfsr_multi_axi: RTL and testbench

// AXI4-Lite slave holding NUM_CH independent Galois LFSR channels; game logic (obstacle spawn, cloud placement) reads them.

---
 rtl/lfsr_pkg.sv | 64 ++++++
 rtl/lfsr_core.sv | 41 ++++
 rtl/lfsr_multi_axi.sv | 217 +++++++++++++++++++++
 tb/tb_lfsr_multi_axi.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the multi-channel LFSR AXI4-Lite peripheral:
// register selectors, CFG step modes, AXI response codes, address decode
// and byte-strobe merge helpers.
package lfsr_pkg;

  // Step mode held in CFG[1:0] of each channel.
  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_RDSTEP = 2'd1,
    MODE_WRSTEP = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // Register within a channel block, taken from addr[3:2]
  // (offsets 0x0 SEED, 0x4 TAPS, 0x8 VALUE, 0xC CFG).
  typedef enum logic [1:0] {
    REG_SEED  = 2'd0,
    REG_TAPS  = 2'd1,
    REG_VALUE = 2'd2,
    REG_CFG   = 2'd3
  } reg_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // CFG bit that turns a CFG write into a STEP command; never stored.
  localparam int unsigned CFG_STEP_BIT = 31;

  typedef struct packed {
    logic       hit;   // address maps to a real register
    logic       ctrl;  // address is CTRL at 0x00
    logic [2:0] ch;    // channel index when hit && !ctrl
    reg_e       sel;   // register within the channel block
  } dec_t;

  // 16-byte slots: slot 0 holds CTRL at offset 0, slot c+1 is channel c.
  function automatic dec_t decode(input logic [31:0] addr, input int unsigned num_ch);
    dec_t        d;
    int unsigned slot;
    d     = '0;
    slot  = {4'b0, addr[31:4]};
    d.sel = reg_e'(addr[3:2]);
    if (slot == 0) begin
      d.ctrl = (addr[3:2] == 2'd0);
      d.hit  = d.ctrl;
    end else if (slot <= num_ch) begin
      d.hit = 1'b1;
      d.ch  = 3'(slot - 1);
    end
    return d;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// One Galois LFSR channel.
// Ports: clk, rst_n (async active-low), en (channel enable, gates stepping
// only), step (advance request), load/load_val (direct state load),
// seed (lock-up replacement value, never zero), taps (feedback mask),
// state (current LFSR state).
// A load always wins over a step; any zero result is replaced by seed.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] taps,
  output logic [W-1:0] state
);

  logic [W-1:0] stepped;
  logic [W-1:0] cand;
  logic [W-1:0] nxt;
  logic         upd;

  always_comb begin
    stepped = state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    upd     = load | (en & step);
    cand    = load ? load_val : stepped;
    nxt     = state;
    if (upd) nxt = (cand == '0) ? seed : cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= W'(1);
    else        state <= nxt;
  end

endmodule

// File: rtl/lfsr_multi_axi.sv
// AXI4-Lite slave exposing NUM_CH independent Galois LFSR channels.
// Ports: s00_axi_* standard AXI4-Lite slave (32-bit data, ADDR_WIDTH
// address, prot ignored), clocked by s00_axi_aclk with async active-low
// s00_axi_aresetn; lfsr_value_o carries the live state of every channel,
// channel 0 in the LSBs.
// Map: 0x00 CTRL enables; channel c at 0x10*(c+1): SEED, TAPS, VALUE, CFG.
module lfsr_multi_axi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned LFSR_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter logic [31:0] DEFAULT_TAPS = 32'h80200003
) (
  input  logic                         s00_axi_aclk,
  input  logic                         s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [2:0]                   s00_axi_awprot,
  input  logic                         s00_axi_awvalid,
  output logic                         s00_axi_awready,
  input  logic [31:0]                  s00_axi_wdata,
  input  logic [3:0]                   s00_axi_wstrb,
  input  logic                         s00_axi_wvalid,
  output logic                         s00_axi_wready,
  output logic [1:0]                   s00_axi_bresp,
  output logic                         s00_axi_bvalid,
  input  logic                         s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [2:0]                   s00_axi_arprot,
  input  logic                         s00_axi_arvalid,
  output logic                         s00_axi_arready,
  output logic [31:0]                  s00_axi_rdata,
  output logic [1:0]                   s00_axi_rresp,
  output logic                         s00_axi_rvalid,
  input  logic                         s00_axi_rready,
  output logic [NUM_CH*LFSR_WIDTH-1:0] lfsr_value_o
);

  import lfsr_pkg::*;

  localparam int unsigned W = LFSR_WIDTH;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e wstate, wstate_nxt;
  rstate_e rstate, rstate_nxt;
  logic    wr_fire, rd_fire;

  dec_t dec_w, dec_r;

  logic [NUM_CH-1:0] ctrl_q;
  logic [W-1:0]      seed_q  [NUM_CH];
  logic [W-1:0]      taps_q  [NUM_CH];
  mode_e             mode_q  [NUM_CH];
  logic [W-1:0]      state   [NUM_CH];
  logic [31:0]       ch_word [NUM_CH][4];

  logic [31:0] wr_old, wr_merged, rd_word;
  logic [W-1:0] wr_trunc, seed_new;

  logic [NUM_CH-1:0] wr_hit, wr_step, rd_step;
  logic [NUM_CH-1:0] core_load, core_step;
  logic [W-1:0]      core_load_val [NUM_CH];

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, wr_merged};

  // ---------------- write channel FSM ----------------
  always_comb begin
    wstate_nxt = wstate;
    wr_fire    = 1'b0;
    case (wstate)
      W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid && s00_axi_aresetn) begin
        wr_fire    = 1'b1;
        wstate_nxt = W_RESP;
      end
      W_RESP: if (s00_axi_bready) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // ---------------- read channel FSM ----------------
  always_comb begin
    rstate_nxt = rstate;
    rd_fire    = 1'b0;
    case (rstate)
      R_IDLE: if (s00_axi_arvalid && s00_axi_aresetn) begin
        rd_fire    = 1'b1;
        rstate_nxt = R_DATA;
      end
      R_DATA: if (s00_axi_rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
    end
  end

  assign s00_axi_awready = wr_fire;
  assign s00_axi_wready  = wr_fire;
  assign s00_axi_arready = rd_fire;
  assign s00_axi_bvalid  = (wstate == W_RESP);
  assign s00_axi_rvalid  = (rstate == R_DATA);

  // ---------------- decode and register view ----------------
  assign dec_w = decode(32'(s00_axi_awaddr), NUM_CH);
  assign dec_r = decode(32'(s00_axi_araddr), NUM_CH);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned r = 0; r < 4; r++) ch_word[c][r] = '0;
      ch_word[c][REG_SEED][W-1:0]  = seed_q[c];
      ch_word[c][REG_TAPS][W-1:0]  = taps_q[c];
      ch_word[c][REG_VALUE][W-1:0] = state[c];
      ch_word[c][REG_CFG][1:0]     = mode_q[c];
    end
  end

  // wr_old is the current contents of the write target so that byte lanes
  // with WSTRB low keep their value; rd_word is the read return value.
  always_comb begin
    wr_old  = '0;
    rd_word = '0;
    if (dec_w.ctrl) wr_old[NUM_CH-1:0]  = ctrl_q;
    if (dec_r.ctrl) rd_word[NUM_CH-1:0] = ctrl_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (dec_w.hit && !dec_w.ctrl && dec_w.ch == 3'(c)) wr_old  = ch_word[c][dec_w.sel];
      if (dec_r.hit && !dec_r.ctrl && dec_r.ch == 3'(c)) rd_word = ch_word[c][dec_r.sel];
    end
  end

  assign wr_merged = strb_merge(wr_old, s00_axi_wdata, s00_axi_wstrb);
  assign wr_trunc  = wr_merged[W-1:0];
  assign seed_new  = (wr_trunc == '0) ? W'(1) : wr_trunc;

  // ---------------- per-channel step/load requests ----------------
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_hit[c]        = wr_fire && dec_w.hit && !dec_w.ctrl && dec_w.ch == 3'(c);
      core_load[c]     = wr_hit[c] && (dec_w.sel == REG_SEED || dec_w.sel == REG_VALUE);
      core_load_val[c] = (dec_w.sel == REG_SEED) ? seed_new : wr_trunc;
      // STEP command is judged against the mode this same write leaves behind.
      wr_step[c]       = wr_hit[c] && dec_w.sel == REG_CFG && wr_merged[CFG_STEP_BIT]
                         && mode_e'(wr_merged[1:0]) == MODE_WRSTEP;
      // Step lands on the AR handshake edge, the same edge that captures
      // rdata, so the read returns the pre-step state.
      rd_step[c]       = rd_fire && dec_r.hit && !dec_r.ctrl && dec_r.ch == 3'(c)
                         && dec_r.sel == REG_VALUE && mode_q[c] == MODE_RDSTEP;
      core_step[c]     = (mode_q[c] == MODE_FREE) || rd_step[c] || wr_step[c];
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        seed_q[c] <= W'(1);
        taps_q[c] <= DEFAULT_TAPS[W-1:0];
        mode_q[c] <= MODE_FREE;
      end
    end else if (wr_fire && dec_w.hit) begin
      if (dec_w.ctrl) begin
        ctrl_q <= wr_merged[NUM_CH-1:0];
      end else begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (dec_w.ch == 3'(c)) begin
            case (dec_w.sel)
              REG_SEED: seed_q[c] <= seed_new;
              REG_TAPS: taps_q[c] <= wr_trunc;
              REG_CFG:  mode_q[c] <= mode_e'(wr_merged[1:0]);
              default:  ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_bresp <= RESP_OKAY;
      s00_axi_rresp <= RESP_OKAY;
      s00_axi_rdata <= '0;
    end else begin
      if (wr_fire) s00_axi_bresp <= dec_w.hit ? RESP_OKAY : RESP_SLVERR;
      if (rd_fire) begin
        s00_axi_rresp <= dec_r.hit ? RESP_OKAY : RESP_SLVERR;
        s00_axi_rdata <= dec_r.hit ? rd_word : '0;
      end
    end
  end

  // ---------------- channels ----------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lfsr_core #(.W(W)) u_core (
      .clk      (s00_axi_aclk),
      .rst_n    (s00_axi_aresetn),
      .en       (ctrl_q[c]),
      .step     (core_step[c]),
      .load     (core_load[c]),
      .load_val (core_load_val[c]),
      .seed     (seed_q[c]),
      .taps     (taps_q[c]),
      .state    (state[c])
    );
    assign lfsr_value_o[c*W +: W] = state[c];
  end

endmodule

// File: tb/tb_lfsr_multi_axi.sv
module tb_lfsr_multi_axi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned W      = 32;
  localparam int unsigned AW     = 7;
  localparam logic [31:0] TAPS   = 32'h80200003;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic          arvalid = 1'b0, rready = 1'b1;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [31:0]   wdata = '0, rdata;
  logic [3:0]    wstrb = '0;
  logic [1:0]    bresp, rresp;
  logic [NUM_CH*W-1:0] lfsr_value;

  always #5 clk = ~clk;

  lfsr_multi_axi #(
    .NUM_CH(NUM_CH), .LFSR_WIDTH(W), .ADDR_WIDTH(AW), .DEFAULT_TAPS(TAPS)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .lfsr_value_o(lfsr_value)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    string       name;
  } exp_t;
  exp_t bq[$];
  exp_t rq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected one within 50 cycles", name);
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] t);
    return s[0] ? ((s >> 1) ^ t) : (s >> 1);
  endfunction

  // Scoreboard monitor: pops an expectation on every response handshake.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bresp %0d expected no response", bresp);
      end else begin
        exp_t e;
        e = bq.pop_front();
        check({e.name, ".bresp"}, bresp, e.resp);
      end
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got rdata %h expected no response", rdata);
      end else begin
        exp_t e;
        e = rq.pop_front();
        check({e.name, ".rdata"}, rdata, e.data);
        check({e.name, ".rresp"}, rresp, e.resp);
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] eresp, input string name, input int hold, output int hs);
    int n;
    @(posedge clk); #1;
    awaddr = addr[AW-1:0]; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
    bq.push_back('{32'h0, eresp, name});
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 50) begin n++; @(negedge clk); end
    if (!(awready && wready)) tmo({name, ".aw"});
    hs = cyc + 1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (hold > 0) begin
      // A second write offered while the response is stalled must not be taken.
      awaddr = 7'h7C; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, ".hold_bvalid"}, bvalid, 1);
        check({name, ".hold_bresp"}, bresp, eresp);
        check({name, ".hold_awready"}, {awready, wready}, 0);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin n++; @(negedge clk); end
    if (!bvalid) tmo({name, ".b"});
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] edata, input logic [1:0] eresp,
                          input string name, input int hold);
    int n;
    @(posedge clk); #1;
    araddr = addr[AW-1:0]; arvalid = 1'b1; rready = (hold == 0);
    rq.push_back('{edata, eresp, name});
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin n++; @(negedge clk); end
    if (!arready) tmo({name, ".ar"});
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (hold > 0) begin
      araddr = 7'h00; arvalid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, ".hold_rvalid"}, rvalid, 1);
        check({name, ".hold_rdata"}, rdata, edata);
        check({name, ".hold_arready"}, arready, 0);
      end
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin n++; @(negedge clk); end
    if (!rvalid) tmo({name, ".r"});
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int hs, e_cyc, d_cyc, n_steps;
    logic [31:0] s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_handshake", {awready, wready, arready, bvalid, rvalid}, 0);
    check("reset_resp", {bresp, rresp}, 0);
    check("reset_rdata", rdata, 0);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("reset_state%0d", i), lfsr_value[i*W +: W], 1);
    rst_n = 1'b1;

    // Reset register contents.
    axi_read(32'h10, 32'h1, OKAY, "rst_seed0", 0);
    axi_read(32'h14, TAPS,  OKAY, "rst_taps0", 0);
    axi_read(32'h18, 32'h1, OKAY, "rst_value0", 0);
    axi_read(32'h1C, 32'h0, OKAY, "rst_cfg0", 0);
    axi_read(32'h00, 32'h0, OKAY, "rst_ctrl", 0);

    // ch0 step-on-write, ch1 step-on-read.
    axi_write(32'h1C, 32'h2, 4'hF, OKAY, "cfg0", 0, hs);
    axi_write(32'h2C, 32'h1, 4'hF, OKAY, "cfg1", 0, hs);
    axi_write(32'h10, 32'h1, 4'hF, OKAY, "seed0", 0, hs);
    axi_write(32'h20, 32'h1, 4'hF, OKAY, "seed1", 0, hs);
    axi_write(32'h00, 32'h3, 4'hF, OKAY, "ctrl_en01", 0, hs);
    axi_write(32'h1C, 32'h80000002, 4'hF, OKAY, "step0_a", 0, hs);
    axi_read(32'h18, 32'h80200003, OKAY, "ch0_step1", 0);
    axi_write(32'h1C, 32'h80000002, 4'hF, OKAY, "step0_b", 0, hs);
    axi_read(32'h18, 32'hC0300002, OKAY, "ch0_step2", 0);
    axi_read(32'h1C, 32'h2, OKAY, "cfg0_readback", 0);
    axi_read(32'h28, 32'h1,        OKAY, "ch1_rd1", 0);
    axi_read(32'h28, 32'h80200003, OKAY, "ch1_rd2", 0);
    axi_read(32'h28, 32'hC0300002, OKAY, "ch1_rd3", 0);
    check("ch1_live_after_rd3", lfsr_value[1*W +: W], 32'h60180001);
    check("ch0_live_unchanged", lfsr_value[0*W +: W], 32'hC0300002);

    // ch2 free-run between the enable and disable handshakes.
    axi_write(32'h00, 32'h7, 4'hF, OKAY, "ctrl_en2", 0, e_cyc);
    repeat (10) @(posedge clk);
    axi_write(32'h00, 32'h3, 4'hF, OKAY, "ctrl_dis2", 0, d_cyc);
    n_steps = d_cyc - e_cyc;
    s = 32'h1;
    for (int i = 0; i < n_steps; i++) s = model_step(s, TAPS);
    axi_read(32'h38, s, OKAY, "ch2_freerun", 0);
    repeat (5) @(posedge clk);
    axi_read(32'h38, s, OKAY, "ch2_frozen", 0);

    // Lock-up protection and byte strobes on ch3 (disabled).
    axi_write(32'h40, 32'h1234, 4'hF, OKAY, "seed3_a", 0, hs);
    axi_write(32'h40, 32'h0,    4'hF, OKAY, "seed3_zero", 0, hs);
    axi_read(32'h40, 32'h1, OKAY, "seed3_is1", 0);
    axi_read(32'h48, 32'h1, OKAY, "value3_seeded", 0);
    axi_write(32'h40, 32'h55, 4'hF, OKAY, "seed3_b", 0, hs);
    axi_write(32'h48, 32'h0,  4'hF, OKAY, "value3_zero", 0, hs);
    axi_read(32'h48, 32'h55, OKAY, "value3_is_seed", 0);
    check("ch3_live", lfsr_value[3*W +: W], 32'h55);
    axi_write(32'h44, 32'hAABBCCDD, 4'b0101, OKAY, "taps3_strb", 0, hs);
    axi_read(32'h44, 32'h80BB00DD, OKAY, "taps3_merged", 0);

    // Unmapped and out-of-range addresses.
    axi_write(32'h7C, 32'hFFFFFFFF, 4'hF, SLVERR, "wr_7c", 0, hs);
    axi_write(32'h50, 32'hFFFFFFFF, 4'hF, SLVERR, "wr_50", 0, hs);
    axi_read(32'h7C, 32'h0, SLVERR, "rd_7c", 0);
    axi_read(32'h04, 32'h0, SLVERR, "rd_04", 0);
    axi_read(32'h00, 32'h3, OKAY, "ctrl_after_err", 0);

    // Backpressure on both response channels.
    axi_write(32'h44, 32'h000000FF, 4'b0001, OKAY, "bp_write", 5, hs);
    axi_read(32'h44, 32'h80BB00FF, OKAY, "bp_read", 5);

    // Asynchronous reset with a write response pending: no response follows.
    @(posedge clk); #1;
    awaddr = 7'h20; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    check("rstmid_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("rstmid_bvalid_before", bvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_handshake", {awready, wready, arready, bvalid, rvalid}, 0);
    check("rstmid_resp", {bresp, rresp}, 0);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("rstmid_state%0d", i), lfsr_value[i*W +: W], 1);
    @(negedge clk);
    bready = 1'b1;
    rst_n = 1'b1;
    axi_read(32'h00, 32'h0, OKAY, "post_rst_ctrl", 0);
    axi_read(32'h20, 32'h1, OKAY, "post_rst_seed1", 0);
    axi_read(32'h44, TAPS,  OKAY, "post_rst_taps3", 0);

    repeat (3) @(posedge clk);
    check("queues_drained", bq.size() + rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
